// File: rtl/lfsr_bist_ctrl.sv
// rtl/lfsr_bist_ctrl.sv - BIST sequencer: LFSR stimulus into a chain, MISR compression of its output, golden compare.
// Outputs are registered from the next-state value, so each one reflects the state it belongs to.
module lfsr_bist_ctrl #(
  parameter int          RST_CYCLES = 2,
  parameter logic [15:0] MISR_POLY  = 16'h002D
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] run_len,
  input  logic [15:0] seed,
  input  logic [15:0] golden,
  input  logic        chain_q,
  output logic        chain_d,
  output logic        chain_rst_n,
  output logic        chain_en,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] signature
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLR    = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_RUN    = 3'd3;
  localparam logic [2:0] S_CMP    = 3'd4;

  localparam logic [15:0] SEED_DEF = 16'hACE1;
  localparam logic [15:0] CLR_LAST = 16'(RST_CYCLES - 1);

  logic [2:0]  state;
  logic [2:0]  state_nx;
  logic [15:0] cnt;
  logic [15:0] run_len_q;
  logic [15:0] stim;
  logic [15:0] stim_nx;
  logic [15:0] sig_nx;

  always_comb begin
    stim_nx = {stim[0] ^ stim[2] ^ stim[3] ^ stim[5], stim[15:1]};
    sig_nx  = {signature[14:0], 1'b0} ^ (signature[15] ? MISR_POLY : 16'h0000)
            ^ {15'b0, chain_q};
  end

  // abort wins over every busy-state transition, including the final RUN cycle
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (start && !abort) state_nx = S_CLR;
      S_CLR:    if (abort) state_nx = S_IDLE;
                else if (cnt == CLR_LAST) state_nx = S_SETTLE;
      S_SETTLE: if (abort) state_nx = S_IDLE;
                else state_nx = (run_len_q == 16'd0) ? S_CMP : S_RUN;
      S_RUN:    if (abort) state_nx = S_IDLE;
                else if (cnt == run_len_q - 16'd1) state_nx = S_CMP;
      S_CMP:    state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      cnt         <= 16'd0;
      run_len_q   <= 16'd0;
      stim        <= SEED_DEF;
      chain_d     <= 1'b0;
      chain_rst_n <= 1'b0;
      chain_en    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      signature   <= 16'd0;
    end else begin
      state       <= state_nx;
      busy        <= (state_nx != S_IDLE);
      chain_en    <= (state_nx == S_RUN);
      chain_rst_n <= (state_nx != S_CLR);
      done        <= (state_nx == S_CMP);
      chain_d     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && !abort) begin
            run_len_q <= run_len;
            stim      <= (seed == 16'd0) ? SEED_DEF : seed;
            signature <= 16'd0;
            pass      <= 1'b0;
            cnt       <= 16'd0;
          end
        end
        S_CLR: begin
          if (!abort) cnt <= (cnt == CLR_LAST) ? 16'd0 : cnt + 16'd1;
        end
        S_SETTLE: begin
          if (state_nx == S_RUN) chain_d <= stim[0];
        end
        S_RUN: begin
          if (!abort) begin
            stim      <= stim_nx;
            signature <= sig_nx;
            cnt       <= cnt + 16'd1;
            if (state_nx == S_RUN) chain_d <= stim_nx[0];
          end
        end
        S_CMP: begin
          pass <= !abort && (signature == golden);
        end
        default: ;
      endcase
      if (abort && state != S_IDLE) pass <= 1'b0;
    end
  end

endmodule
